// File: rtl/alu_pkg.sv
// Shared definitions for the pipelined ALU.
// Opcodes and flag-vector layout used by core, pipe and bench.
package alu_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SLL = 3'b101;
    localparam logic [2:0] OP_SRL = 3'b110;
    localparam logic [2:0] OP_SRA = 3'b111;

    // Flag vector layout: {ovf, carry, neg, zero}
    localparam int FLAG_ZERO  = 0;
    localparam int FLAG_NEG   = 1;
    localparam int FLAG_CARRY = 2;
    localparam int FLAG_OVF   = 3;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: arithmetic, logic, shifts and flags.
// Only B[SHW-1:0] is used as the shift amount.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [2:0]       op_i,
    output logic [WIDTH-1:0] result_o,
    output logic [3:0]       flags_o
);

    localparam int SHW = $clog2(WIDTH);

    logic             sub;
    logic [WIDTH-1:0] bx;
    logic [WIDTH:0]   sum;
    logic [SHW-1:0]   shamt;
    logic             arith;

    always_comb begin
        sub      = (op_i == OP_SUB);
        bx       = sub ? ~b_i : b_i;
        sum      = {1'b0, a_i} + {1'b0, bx} + {{WIDTH{1'b0}}, sub};
        shamt    = b_i[SHW-1:0];
        arith    = (op_i == OP_ADD) || (op_i == OP_SUB);
        result_o = '0;
        unique case (op_i)
            OP_ADD,
            OP_SUB: result_o = sum[WIDTH-1:0];
            OP_AND: result_o = a_i & b_i;
            OP_OR:  result_o = a_i | b_i;
            OP_XOR: result_o = a_i ^ b_i;
            OP_SLL: result_o = a_i << shamt;
            OP_SRL: result_o = a_i >> shamt;
            OP_SRA: result_o = $unsigned($signed(a_i) >>> shamt);
        endcase
        flags_o             = '0;
        flags_o[FLAG_ZERO]  = (result_o == '0);
        flags_o[FLAG_NEG]   = result_o[WIDTH-1];
        flags_o[FLAG_CARRY] = arith & sum[WIDTH];
        flags_o[FLAG_OVF]   = arith
                            & (a_i[WIDTH-1] == bx[WIDTH-1])
                            & (sum[WIDTH-1] != a_i[WIDTH-1]);
    end

endmodule

// File: rtl/dff.sv
// Enabled D flip-flop cell with asynchronous active-low clear.
// Holds its value whenever en_i is low.
module dff #(
    parameter int W = 1
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         en_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            q_o <= '0;
        end else if (en_i) begin
            q_o <= d_i;
        end
    end

endmodule

// File: rtl/alu_pipe.sv
// Two-stage valid/ready pipelined ALU; one operation per cycle.
// Stage 1 registers operands, stage 2 registers result and flags.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [2:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_zero,
    output logic             out_neg,
    output logic             out_carry,
    output logic             out_ovf
);

    logic             en;
    logic             ld1;
    logic             ld2;
    logic             v1_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] res_d;
    logic [WIDTH-1:0] res_q;
    logic [3:0]       flg_d;
    logic [3:0]       flg_q;

    // The whole pipe advances together unless a result is stuck at the output
    assign en       = !out_valid_q || out_ready;
    assign in_ready = en;
    assign ld1      = in_valid && en;
    assign ld2      = v1_q && en;

    dff #(.W(1)) u_v1 (
        .clk_i(clk), .rst_n_i(rst_n), .en_i(en),
        .d_i(in_valid), .q_o(v1_q)
    );

    dff #(.W(2 * WIDTH + 3)) u_s1 (
        .clk_i(clk), .rst_n_i(rst_n), .en_i(ld1),
        .d_i({in_a, in_b, in_op}), .q_o({a_q, b_q, op_q})
    );

    alu_core #(.WIDTH(WIDTH)) u_core (
        .a_i(a_q), .b_i(b_q), .op_i(op_q),
        .result_o(res_d), .flags_o(flg_d)
    );

    dff #(.W(1)) u_v2 (
        .clk_i(clk), .rst_n_i(rst_n), .en_i(en),
        .d_i(v1_q), .q_o(out_valid_q)
    );

    dff #(.W(WIDTH + 4)) u_s2 (
        .clk_i(clk), .rst_n_i(rst_n), .en_i(ld2),
        .d_i({res_d, flg_d}), .q_o({res_q, flg_q})
    );

    assign out_valid  = out_valid_q;
    assign out_result = res_q;
    assign out_zero   = flg_q[FLAG_ZERO];
    assign out_neg    = flg_q[FLAG_NEG];
    assign out_carry  = flg_q[FLAG_CARRY];
    assign out_ovf    = flg_q[FLAG_OVF];

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe at WIDTH=8.
// Expectations come from an integer reference model.
module tb_alu_pipe;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_a = '0;
    logic [W-1:0] in_b = '0;
    logic [2:0]   in_op = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] out_result;
    logic         out_zero;
    logic         out_neg;
    logic         out_carry;
    logic         out_ovf;

    alu_pipe #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_op(in_op),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_zero(out_zero),
        .out_neg(out_neg), .out_carry(out_carry), .out_ovf(out_ovf)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [11:0] sb_q[$];
    int          hs_q[$];
    int          total = 0;
    int          bad = 0;
    int          acc_edge = 0;
    logic [11:0] mon_exp;

    // {ovf, carry, neg, zero, result[7:0]}
    function automatic logic [11:0] model(input logic [7:0] a,
                                          input logic [7:0] b,
                                          input logic [2:0] op);
        int ua, ub, sa, sb, s, amt;
        logic [7:0] r;
        logic c, v;
        ua = a; ub = b;
        sa = $signed(a); sb = $signed(b);
        amt = ub % 8;
        c = 1'b0; v = 1'b0; r = '0; s = 0;
        case (op)
            3'd0: begin
                s = ua + ub; r = s[7:0]; c = (s > 255);
                v = (sa + sb > 127) || (sa + sb < -128);
            end
            3'd1: begin
                s = ua - ub; r = s[7:0]; c = (ua >= ub);
                v = (sa - sb > 127) || (sa - sb < -128);
            end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: begin s = ua << amt; r = s[7:0]; end
            3'd6: begin s = ua >> amt; r = s[7:0]; end
            3'd7: begin s = sa >>> amt; r = s[7:0]; end
            default: r = '0;
        endcase
        return {v, c, r[7], (r == 8'h00), r};
    endfunction

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            total++;
            if (sb_q.size() == 0) begin
                bad++;
                $display("FAIL sb_unexpected got=%h", out_result);
            end else begin
                mon_exp = sb_q.pop_front();
                if ({out_ovf, out_carry, out_neg, out_zero, out_result}
                    !== mon_exp) begin
                    bad++;
                    $display("FAIL sb_result got=%h exp=%h",
                        {out_ovf, out_carry, out_neg, out_zero, out_result},
                        mon_exp);
                end
            end
            hs_q.push_back(cyc + 1);
        end
    end

    task automatic issue(input logic [7:0] a, input logic [7:0] b,
                         input logic [2:0] op);
        bit acc;
        int n;
        in_valid = 1'b1; in_a = a; in_b = b; in_op = op;
        acc = 1'b0; n = 0;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!acc) begin
            total++; bad++;
            $display("FAIL accept_timeout op=%0d", op);
        end else begin
            sb_q.push_back(model(a, b, op));
            acc_edge = cyc;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        in_valid = 1'b0;
        while (sb_q.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        #1;
        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL drain_timeout left=%0d req=0", sb_q.size());
        end
    endtask

    task automatic test_reset();
        #3;
        total++;
        if ({out_valid, out_result, out_ovf, out_carry, out_neg, out_zero,
             in_ready} !== 14'b00000000000001) begin
            bad++;
            $display("FAIL reset_state v=%b r=%h rdy=%b", out_valid,
                     out_result, in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_release rdy=%b v=%b req=1/0", in_ready,
                     out_valid);
        end
    endtask

    task automatic test_add_ovf();
        out_ready = 1'b1;
        issue(8'h7F, 8'h01, 3'd0);
        in_valid = 1'b0;
        @(negedge clk);
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL add_early v=%b req=0", out_valid);
        end
        @(negedge clk);
        total++;
        if ({out_valid, out_result, out_ovf, out_carry, out_neg, out_zero}
            !== {1'b1, 8'h80, 4'b1010}) begin
            bad++;
            $display("FAIL add_ovf got=%b_%h_%b%b%b%b req=1_80_1010",
                     out_valid, out_result, out_ovf, out_carry, out_neg,
                     out_zero);
        end
        drain();
    endtask

    task automatic test_sub();
        issue(8'h05, 8'h05, 3'd1);
        issue(8'h03, 8'h05, 3'd1);
        issue(8'h80, 8'h01, 3'd1);
        issue(8'hFF, 8'h01, 3'd0);
        drain();
    endtask

    task automatic test_shift_logic();
        issue(8'h80, 8'h03, 3'd7);
        issue(8'h80, 8'h0B, 3'd6);
        issue(8'h81, 8'h00, 3'd5);
        issue(8'h01, 8'hFF, 3'd5);
        issue(8'h40, 8'h06, 3'd7);
        for (int i = 0; i < 24; i++) begin
            issue(8'($urandom), 8'($urandom), 3'(i % 8));
        end
        drain();
    endtask

    task automatic test_back_to_back();
        int first;
        hs_q.delete();
        for (int i = 0; i < 8; i++) begin
            issue(8'(i), 8'(i), 3'd0);
            if (i == 0) first = acc_edge;
        end
        drain();
        total++;
        if (hs_q.size() != 8) begin
            bad++;
            $display("FAIL b2b_count got=%0d req=8", hs_q.size());
        end else begin
            for (int k = 0; k < 8; k++) begin
                total++;
                if (hs_q[k] != first + 2 + k) begin
                    bad++;
                    $display("FAIL b2b_timing k=%0d got=%0d req=%0d", k,
                             hs_q[k], first + 2 + k);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] held;
        int n;
        hs_q.delete();
        out_ready = 1'b1;
        fork
            begin
                issue(8'h11, 8'h22, 3'd4);
                issue(8'h33, 8'h0F, 3'd3);
                issue(8'hF0, 8'h3C, 3'd2);
                issue(8'h10, 8'h20, 3'd1);
                in_valid = 1'b0;
            end
            begin
                n = 0;
                @(negedge clk);
                while (!out_valid && n < 50) begin
                    @(negedge clk);
                    n++;
                end
                total++;
                if (!out_valid) begin
                    bad++;
                    $display("FAIL bp_first_timeout v=%b req=1", out_valid);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b0;
                @(negedge clk);
                held = out_result;
                total++;
                if (held !== 8'h3F) begin
                    bad++;
                    $display("FAIL bp_held got=%h req=3f", held);
                end
                for (int k = 0; k < 5; k++) begin
                    total++;
                    if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
                        out_result !== held) begin
                        bad++;
                        $display("FAIL bp_stall k=%0d v=%b rdy=%b r=%h req=1/0/%h",
                                 k, out_valid, in_ready, out_result, held);
                    end
                    if (k < 4) @(negedge clk);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();
        total++;
        if (hs_q.size() != 4) begin
            bad++;
            $display("FAIL bp_count got=%0d req=4", hs_q.size());
        end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b1;
        issue(8'h01, 8'h02, 3'd0);
        issue(8'h03, 8'h04, 3'd0);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({out_valid, out_result, out_ovf, out_carry, out_neg, out_zero,
             in_ready} !== 14'b00000000000001) begin
            bad++;
            $display("FAIL rst_mid v=%b r=%h rdy=%b req=0/00/1", out_valid,
                     out_result, in_ready);
        end
        sb_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid_release rdy=%b v=%b req=1/0", in_ready,
                     out_valid);
        end
        issue(8'h09, 8'h06, 3'd1);
        in_valid = 1'b0;
        @(negedge clk);
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL rst_new_early v=%b req=0", out_valid);
        end
        @(negedge clk);
        total++;
        if (out_valid !== 1'b1 || out_result !== 8'h03) begin
            bad++;
            $display("FAIL rst_new_result v=%b r=%h req=1/03", out_valid,
                     out_result);
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_add_ovf();
        test_sub();
        test_shift_logic();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

endmodule
